// File: rtl/md_sequencer_if.sv
// Bundle of the control-unit facing signals of the multiply/divide sequencer:
// operation launch, abort, MTHI/MTLO writes, and the stall/complete/HI/LO returns.
interface md_sequencer_if #(
   parameter int W = 32
);
   logic         start;
   logic [1:0]   md_op;
   logic [W-1:0] rs_data;
   logic [W-1:0] rt_data;
   logic         flush;
   logic         hi_we;
   logic         lo_we;
   logic [W-1:0] wdata;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   // Control unit side: issues operations and register writes.
   modport master (
      output start, md_op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   // Sequencer side: owns HI/LO and the stall request.
   modport slave (
      input  start, md_op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Operands are reduced to magnitudes at launch, W unsigned shift-add or
// restoring-divide steps run in CALC, and the sign fix-up plus HI/LO write
// happen in FIX. busy stalls the pipeline from the launch cycle onward.
module md_sequencer #(
   parameter int W     = 32,
   parameter int CNT_W = 5
) (
   input logic          clk,
   input logic          rst,
   md_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [2*W-1:0]   acc;        // multiply: {partial product, multiplier}; divide: {remainder, quotient}
   logic [W-1:0]     opnd;       // multiplicand magnitude or divisor magnitude
   logic             is_div;
   logic             neg_main;   // negate product (multiply) or quotient (divide)
   logic             neg_rem;    // negate remainder (divide only)
   logic [W-1:0]     hi_q;
   logic [W-1:0]     lo_q;
   logic             busy;
   logic             done;

   // Launch-time operand preparation and per-step arithmetic.
   logic             op_signed;
   logic [W-1:0]     abs_rs;
   logic [W-1:0]     abs_rt;
   logic [W:0]       mul_sum;
   logic [2*W-1:0]   mul_next;
   logic [W:0]       rem_sh;
   logic             div_ge;
   logic [W-1:0]     rem_sub;
   logic [2*W-1:0]   div_next;
   logic [2*W-1:0]   prod_fix;
   logic [W-1:0]     quo_fix;
   logic [W-1:0]     rem_fix;

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state logic plus the stall request and completion pulse.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_n = state;
      busy    = bus.start | (state != IDLE);
      done    = 1'b0;
      case (state)
         IDLE: if (bus.start && !bus.flush) state_n = CALC;
         CALC: begin
            if (bus.flush)              state_n = IDLE;
            else if (cnt == LAST_STEP)  state_n = FIX;
         end
         FIX: begin
            state_n = IDLE;
            done    = !bus.flush;
         end
         default: state_n = IDLE;
      endcase
   end

   // Operand magnitudes, one multiply/divide step, and the final sign fix-up.
   always_comb begin
      op_signed = ~bus.md_op[0];
      abs_rs    = (op_signed && bus.rs_data[W-1]) ? -bus.rs_data : bus.rs_data;
      abs_rt    = (op_signed && bus.rt_data[W-1]) ? -bus.rt_data : bus.rt_data;

      // Shift-add: add multiplicand to the upper half when the current multiplier bit is set,
      // then shift the whole accumulator right so the carry lands in the top bit.
      mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      mul_next = {mul_sum, acc[W-1:1]};

      // Restoring divide: remainder shifted left with the next dividend bit is W+1 bits wide.
      // Whenever the subtract happens the result is below the divisor, so W bits suffice.
      rem_sh   = acc[2*W-1:W-1];
      div_ge   = rem_sh >= {1'b0, opnd};
      rem_sub  = rem_sh[W-1:0] - opnd;
      div_next = {(div_ge ? rem_sub : rem_sh[W-1:0]), acc[W-2:0], div_ge};

      prod_fix = neg_main ? -acc : acc;
      quo_fix  = neg_main ? -acc[W-1:0] : acc[W-1:0];
      rem_fix  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
   end

   // Datapath: MTHI/MTLO and launch in IDLE, one step per CALC cycle, HI/LO write ending FIX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.hi_we) hi_q <= bus.wdata;
               if (bus.lo_we) lo_q <= bus.wdata;
               if (bus.start && !bus.flush) begin
                  cnt     <= '0;
                  is_div  <= bus.md_op[1];
                  // A zero divisor leaves quotient all-ones and remainder = dividend magnitude;
                  // suppressing the quotient negate and keeping the remainder sign returns rs itself.
                  neg_main <= op_signed && (bus.rs_data[W-1] ^ bus.rt_data[W-1]) &&
                              (bus.rt_data != '0);
                  neg_rem  <= op_signed && bus.md_op[1] && bus.rs_data[W-1];
                  if (bus.md_op[1]) begin
                     opnd <= abs_rt;
                     acc  <= {{W{1'b0}}, abs_rs};
                  end else begin
                     opnd <= abs_rs;
                     acc  <= {{W{1'b0}}, abs_rt};
                  end
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               acc <= is_div ? div_next : mul_next;
            end
            FIX: begin
               if (!bus.flush) begin
                  if (is_div) begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end else begin
                     hi_q <= prod_fix[2*W-1:W];
                     lo_q <= prod_fix[W-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
